snake_dir_input: RTL
====================

Name: snake_dir_input

Overview:
- Per-player direction input controller for the snake game.
- Replaces the combinational button-to-move decode with a registered path: synchroniser, debouncer, press-edge detector, turn-validity filter and a small per-player turn queue.
- The queue is drained one entry per game tick.
- Sits between the board buttons and the snake engine. Drives the engine's move inputs with the existing codes: 1 up, 2 right, 3 down, 4 left, 5 none.

Parameters:
- NUM_PLAYERS, default 2: number of independent players/channels.
- DEBOUNCE_CYCLES, default 250000: consecutive stable cycles required to accept a button level change.
- QUEUE_DEPTH, default 2: turn-queue entries per player (power of two, >=1).

Ports:
- clock, input, 1: system clock; single clock domain.
- reset, input, 1: synchronous, active-high reset.
- btn, input, 4*NUM_PLAYERS: raw buttons; player p uses bits [4p+3:4p] = {up,right,down,left}; active-high, asynchronous to clock.
- game_tick, input, 1: one-cycle pulse when the snake engine advances one step.
- move, output, 3*NUM_PLAYERS: player p direction code at [3p+2:3p].
- pending, output, NUM_PLAYERS*$clog2(QUEUE_DEPTH+1): per-player queue occupancy.
- overflow, output, NUM_PLAYERS: sticky per-player flag, set when a valid turn is dropped because the queue is full.

Behaviour:
- Reset (sync, active-high), taking effect at the next clock edge:
  - move = 5 for every player; pending = 0; overflow = 0.
  - Synchroniser flops, debounced levels and debounce counters = 0.
  - Reset wins over every same-cycle event and aborts a partial debounce.
- Synchroniser: 2-flop chain per button bit.
- Debounce, per bit:
  - Counter increments while the synced value differs from the stable value.
  - Counter clears to 0 on any cycle the synced value equals the stable value.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable value flips and the counter clears.
- Press event: a one-cycle pulse on the rising edge of the stable value, registered.
  - Press-to-queue latency = DEBOUNCE_CYCLES+3 clocks from the first steady raw high.
  - Releases generate nothing.
- Per-player arbitration: the 4-bit press vector must be exactly one-hot; zero or multiple simultaneous presses are discarded that cycle.
- Reference direction R = queue tail if pending>0, else move.
- Filter: a candidate direction D is rejected if D==R, or if R!=5 and D is opposite of R (1<->3, 2<->4).
  - With R==5, any direction is accepted.
- Queue (FIFO per player):
  - An accepted D is pushed.
  - If the queue is full and no pop occurs that cycle, D is dropped and overflow[p] is set; overflow stays set until reset.
  - On game_tick with pending>0: the head is popped and written to move (visible the cycle after the tick).
  - On game_tick with pending==0: move holds.
- Simultaneous push and game_tick:
  - The pop uses the old head; the push appends; pending is unchanged (a full queue accepts the push in this case).
  - With an empty queue, the pushed entry is not bypassed to move; it waits for the next tick.
  - R is evaluated on pre-update state; the popped head equals the new move, so the result is consistent.
- Players are fully independent; no cross-player interaction.

Optional Feature:
- Macro: SNAKE_DIR_PS2_EN.
- When defined:
  - Adds inputs ps2_key_pressed (1) and ps2_key_data (8).
  - A ps2_key_pressed pulse with a known scan code produces a press event that is OR-ed into that player's press vector before the one-hot check.
  - Player 0 scan codes: W 1D=up, D 23=right, S 1B=down, A 1C=left.
  - Player 1 scan codes (present only if NUM_PLAYERS>1): I 43=up, L 4B=right, K 42=down, J 3B=left.
  - Unknown codes are ignored. The PS/2 path is not debounced.
- When undefined: the ports are absent and behaviour is buttons-only.

Test Plan (DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2, NUM_PLAYERS=2):
1. Assert reset 3 cycles -> move=5/5, pending=0/0, overflow=00; a tick with no input leaves move=5.
2. P0 up held steady 10 cycles -> pending[0]=1 exactly 7 clocks after first high; tick -> move[2:0]=1 next cycle, pending[0]=0; P1 still 5.
3. P0 up toggled every 2 cycles for 20 cycles, then held low -> no event, pending[0]=0, move unchanged.
4. move[2:0]=1, press down -> rejected (pending 0); press right then down -> queue {2,3}; two ticks -> move 2 then 3.
5. Queue {2,3} full, press left, no tick -> dropped, overflow[0]=1 and still 1 after 2 ticks; reset clears it.
6. P0 right and left debounced in the same cycle -> discarded; separately, accepted push on the tick cycle with an empty queue -> move unchanged that tick, updates on the next tick.

Source files
------------

// File: rtl/snake_dir_input.sv
// snake_dir_input: per-player direction controller for the snake engine.
// Buttons are synchronised, debounced and edge-detected into press events.
// Each press is filtered against the current heading and queued. The queue
// is drained one entry per game_tick.
// Ports:
//   clock, reset - system clock and synchronous active-high reset
//   btn          - raw buttons, {up,right,down,left} per player, async
//   game_tick    - one-cycle engine step pulse
//   move         - per-player direction code (1 up,2 right,3 down,4 left,5 none)
//   pending      - per-player queue occupancy
//   overflow     - sticky per-player queue-full drop flag
//   ps2_key_pressed, ps2_key_data - keyboard path, only with SNAKE_DIR_PS2_EN
// Optional feature macro: SNAKE_DIR_PS2_EN.
module snake_dir_input #(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int QUEUE_DEPTH     = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [4*NUM_PLAYERS-1:0]    btn,
  input  logic                        game_tick,
`ifdef SNAKE_DIR_PS2_EN
  input  logic                        ps2_key_pressed,
  input  logic [7:0]                  ps2_key_data,
`endif
  output logic [3*NUM_PLAYERS-1:0]    move,
  output logic [NUM_PLAYERS*$clog2(QUEUE_DEPTH+1)-1:0] pending,
  output logic [NUM_PLAYERS-1:0]      overflow
);

  localparam int NB = 4 * NUM_PLAYERS;
  localparam int PW = $clog2(QUEUE_DEPTH + 1);
  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_DOWN  = 3'd3;
  localparam logic [2:0] DIR_LEFT  = 3'd4;
  localparam logic [2:0] DIR_NONE  = 3'd5;

  function automatic logic is_opposite(
    input logic [2:0] a,
    input logic [2:0] b
  );
    return (a == DIR_UP    && b == DIR_DOWN)  ||
           (a == DIR_DOWN  && b == DIR_UP)    ||
           (a == DIR_RIGHT && b == DIR_LEFT)  ||
           (a == DIR_LEFT  && b == DIR_RIGHT);
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(QUEUE_DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] stable;
  logic [NB-1:0] press_q;
  logic [CW-1:0] db_cnt [NB];

  // press_q pulses in the same edge the stable level rises, so it is
  // already a registered rising-edge event.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      stable  <= '0;
      press_q <= '0;
      for (int i = 0; i < NB; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      for (int i = 0; i < NB; i++) begin
        press_q[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i]  <= sync2[i];
          db_cnt[i]  <= '0;
          press_q[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [3:0]    key_vec;
    logic [3:0]    press_vec;
    logic          valid;
    logic [2:0]    dir;
    logic [2:0]    ref_dir;
    logic          accept;
    logic          full;
    logic          pop;
    logic          push;
    logic [2:0]    move_q;
    logic [2:0]    last_q;
    logic [2:0]    mem [QUEUE_DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] wptr;
    logic [PW-1:0] cnt;
    logic          ovf;

`ifdef SNAKE_DIR_PS2_EN
    always_comb begin
      key_vec = '0;
      if (ps2_key_pressed) begin
        if (p == 0) begin
          case (ps2_key_data)
            8'h1D:   key_vec = 4'b1000;
            8'h23:   key_vec = 4'b0100;
            8'h1B:   key_vec = 4'b0010;
            8'h1C:   key_vec = 4'b0001;
            default: key_vec = '0;
          endcase
        end else if (p == 1) begin
          case (ps2_key_data)
            8'h43:   key_vec = 4'b1000;
            8'h4B:   key_vec = 4'b0100;
            8'h42:   key_vec = 4'b0010;
            8'h3B:   key_vec = 4'b0001;
            default: key_vec = '0;
          endcase
        end
      end
    end
`else
    assign key_vec = '0;
`endif

    assign press_vec = press_q[4*p +: 4] | key_vec;

    // Only a single simultaneous press is meaningful; anything else
    // is discarded.
    always_comb begin
      valid = 1'b1;
      dir   = DIR_NONE;
      case (press_vec)
        4'b1000: dir = DIR_UP;
        4'b0100: dir = DIR_RIGHT;
        4'b0010: dir = DIR_DOWN;
        4'b0001: dir = DIR_LEFT;
        default: valid = 1'b0;
      endcase
    end

    // Filter against where the snake will be heading once the queue
    // has drained: the newest queued turn, else the current move.
    assign ref_dir = (cnt != '0) ? last_q : move_q;
    assign accept  = valid && (dir != ref_dir) &&
                     !is_opposite(dir, ref_dir);
    assign full    = (cnt == PW'(QUEUE_DEPTH));
    assign pop     = game_tick && (cnt != '0);
    assign push    = accept && (!full || pop);

    always_ff @(posedge clock) begin
      if (reset) begin
        move_q <= DIR_NONE;
        last_q <= DIR_NONE;
        head   <= '0;
        wptr   <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
          mem[i] <= DIR_NONE;
        end
      end else begin
        if (pop) begin
          move_q <= mem[head];
          head   <= ptr_inc(head);
        end
        if (push) begin
          mem[wptr] <= dir;
          wptr      <= ptr_inc(wptr);
          last_q    <= dir;
        end
        if (accept && !push) begin
          ovf <= 1'b1;
        end
        if (push && !pop) begin
          cnt <= cnt + PW'(1);
        end else if (pop && !push) begin
          cnt <= cnt - PW'(1);
        end
      end
    end

    assign move[3*p +: 3]     = move_q;
    assign pending[PW*p +: PW] = cnt;
    assign overflow[p]         = ovf;
  end

endmodule
